// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-port memory responder with programmable wait states and byte/halfword lanes; optional misalignment check under DMEM_ALIGN_CHECK_EN
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  sel_i,
  input  logic        we_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First WAIT cycle holds LATENCY-1 so the access edge lands after LATENCY wait states.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t state;
  state_t state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  logic req;

  // Request fields held from the IDLE edge so a withdrawn request still completes.
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_data;
  logic [1:0]            req_sel;
  logic                  req_we;
  logic                  req_rd;

  // Fields of the access actually being performed this cycle.
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_data;
  logic [1:0]            acc_sel;
  logic                  acc_we;
  logic                  acc_rd;

  logic        do_access;
  logic        do_write;
  logic        do_read;
  logic        misaligned;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  // Address bits above the RAM index alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:ADDR_WIDTH+2];

  assign req = rd_i | we_i;

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, wait countdown and the combinational valid handshake.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    valid_o    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        valid_o = ~req;
        if (req) begin
          if (LATENCY == 0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        valid_o    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the request at the IDLE edge; inputs are ignored until the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      req_addr <= addr_i[ADDR_WIDTH+1:0];
      req_data <= data_i;
      req_sel  <= sel_i;
      req_we   <= we_i;
      req_rd   <= rd_i;
    end
  end

  // With zero wait states the access happens at the IDLE edge straight from the inputs.
  always_comb begin
    acc_addr  = (state == ST_IDLE) ? addr_i[ADDR_WIDTH+1:0] : req_addr;
    acc_data  = (state == ST_IDLE) ? data_i : req_data;
    acc_sel   = (state == ST_IDLE) ? sel_i  : req_sel;
    acc_we    = (state == ST_IDLE) ? we_i   : req_we;
    acc_rd    = (state == ST_IDLE) ? rd_i   : req_rd;
    acc_idx   = acc_addr[ADDR_WIDTH+1:2];
    do_access = ((state == ST_IDLE) && req && (LATENCY == 0)) ||
                ((state == ST_WAIT) && (cnt == 4'd0));
  end

  // Little-endian lane steering; narrow write data is replicated so any lane can pick it up.
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = acc_data;
    case (acc_sel)
      2'b00: begin
        lane_mask = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_data[7:0]}};
      end
      2'b01: begin
        lane_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_data[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = acc_data;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic fault_q;

  // Halfwords must be 2-byte aligned and words 4-byte aligned.
  always_comb begin
    misaligned = 1'b0;
    if (acc_sel == 2'b01) begin
      misaligned = acc_addr[0];
    end else if (acc_sel[1]) begin
      misaligned = (acc_addr[1:0] != 2'b00);
    end
  end

  // Remember whether the performed access was misaligned; shown only while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (do_access) begin
      fault_q <= misaligned;
    end
  end

  assign fault_o = (state == ST_DONE) & fault_q;
`else
  assign misaligned = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // Write wins over read when both are requested; faulted accesses touch nothing.
  assign do_write = do_access & acc_we & ~misaligned;
  assign do_read  = do_access & acc_rd & ~acc_we & ~misaligned;

  // RAM byte-lane writes; a reset at the access edge suppresses the write, contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) begin
          mem[acc_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Read data register; updated only by a performed read and held across writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= 32'd0;
    end else if (do_read) begin
      data_o <= mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with a behavioural memory model
module tb_dmem_responder;

  localparam int AW  = 6;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i, data_i, data_o;
  logic [1:0]  sel_i;
  logic        we_i, rd_i, valid_o, fault_o;

  logic [31:0] z_addr, z_data_i, z_data_o;
  logic [1:0]  z_sel;
  logic        z_we, z_rd, z_valid, z_fault;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
    .we_i(we_i), .rd_i(rd_i), .data_o(data_o), .valid_o(valid_o), .fault_o(fault_o)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .addr_i(z_addr), .data_i(z_data_i), .sel_i(z_sel),
    .we_i(z_we), .rd_i(z_rd), .data_o(z_data_o), .valid_o(z_valid), .fault_o(z_fault)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [0:(2**AW)-1];
  logic [31:0] last_read;
  int          checks = 0;
  int          errors = 0;
  bit          in_txn = 0;
  int          cyc = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [1:0] sel, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sel == 2'b01) return a[0];
    if (sel[1]) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one completed access; pushes what DONE must show.
  task automatic model_issue(input bit we, input bit rd, input logic [1:0] sel,
                             input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    int   off;
    idx = int'(a[AW+1:2]);
    off = int'(a[1:0]);
    e.fault = is_misaligned(sel, a);
    if (!e.fault) begin
      if (we) begin
        if (sel == 2'b00) model[idx][8*off +: 8] = d[7:0];
        else if (sel == 2'b01) model[idx][16*(off/2) +: 16] = d[15:0];
        else model[idx] = d;
      end else if (rd) begin
        last_read = model[idx];
      end
    end
    e.data = last_read;
    sb.push_back(e);
  endtask

  // Present one request as the core would, holding it until valid unless withdrawn in cycle 1.
  task automatic xfer(input bit we, input bit rd, input logic [1:0] sel,
                      input logic [31:0] a, input logic [31:0] d, input bit drop);
    bit ok;
    model_issue(we, rd, sel, a, d);
    we_i = we; rd_i = rd; sel_i = sel; addr_i = a; data_i = d;
    if (drop) begin
      @(posedge clk); #1;
      we_i = 1'b0; rd_i = 1'b0; addr_i = $urandom; data_i = $urandom; sel_i = 2'($urandom);
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no valid expected valid within 40 cycles");
    end
    @(posedge clk); #1;
    we_i = 1'b0; rd_i = 1'b0;
  endtask

  // Start a word write and reset in the given cycle of its wait period; nothing may commit.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] d, input int at);
    we_i = 1'b1; rd_i = 1'b0; sel_i = 2'b10; addr_i = a; data_i = d;
    repeat (at) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_read = 32'd0;
    @(negedge clk);
    check32("post_reset_valid", {31'd0, valid_o}, 32'd1);
    check32("post_reset_data", data_o, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: follows each request from first presentation to its valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_txn = 1'b0;
    end else if (in_txn) begin
      cyc++;
      if (valid_o) begin
        in_txn = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid expected no completion");
        end else begin
          e = sb.pop_front();
          check32("latency", cyc, LAT + 1);
          check32("data_o", data_o, e.data);
          check32("fault_o", {31'd0, fault_o}, {31'd0, e.fault});
        end
      end else begin
        check32("fault_o_idle", {31'd0, fault_o}, 32'd0);
      end
    end else if (rd_i | we_i) begin
      in_txn = 1'b1;
      cyc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200us");
    $fatal(1, "bench did not terminate in time");
  end

  initial begin
    logic [31:0] a, d;
    int op;
    rst = 1'b1;
    we_i = 0; rd_i = 0; sel_i = 0; addr_i = 0; data_i = 0;
    z_we = 0; z_rd = 0; z_sel = 0; z_addr = 0; z_data_i = 0;
    last_read = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("reset_data_o", data_o, 32'd0);
    check32("reset_valid_o", {31'd0, valid_o}, 32'd1);
    check32("reset_fault_o", {31'd0, fault_o}, 32'd0);
    check32("reset_z_data_o", z_data_o, 32'd0);

    // Zero-latency instance: request cycle has valid low, next cycle is DONE.
    @(posedge clk); #1;
    z_we = 1; z_sel = 2'b10; z_addr = 32'h20; z_data_i = 32'hCAFEF00D;
    @(negedge clk);
    check32("lat0_wr_c0_valid", {31'd0, z_valid}, 32'd0);
    @(posedge clk); #1;
    z_we = 0;
    @(negedge clk);
    check32("lat0_wr_c1_valid", {31'd0, z_valid}, 32'd1);
    @(posedge clk); #1;
    z_rd = 1; z_sel = 2'b10; z_addr = 32'h20;
    @(negedge clk);
    check32("lat0_rd_c0_valid", {31'd0, z_valid}, 32'd0);
    @(posedge clk); #1;
    z_rd = 0;
    @(negedge clk);
    check32("lat0_rd_c1_valid", {31'd0, z_valid}, 32'd1);
    check32("lat0_rd_c1_data", z_data_o, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < 2**AW; i++) xfer(1, 0, 2'b10, 32'(i * 4), $urandom, 0);

    xfer(1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    xfer(0, 1, 2'b10, 32'h10, 32'h0, 0);
    xfer(1, 0, 2'b10, 32'h10, 32'h11223344, 0);
    xfer(1, 0, 2'b00, 32'h13, 32'h000000AA, 0);
    xfer(0, 1, 2'b10, 32'h10, 32'h0, 0);
    xfer(1, 0, 2'b01, 32'h12, 32'h00005566, 0);
    xfer(0, 1, 2'b10, 32'h10, 32'h0, 0);
    xfer(1, 1, 2'b10, 32'h10, 32'h0BADF00D, 0);
    xfer(0, 1, 2'b10, 32'h10, 32'h0, 0);

    xfer(1, 0, 2'b10, 32'h04, 32'h0, 0);
    xfer(1, 0, 2'b10, 32'h06, 32'h12345678, 0);
    xfer(0, 1, 2'b10, 32'h04, 32'h0, 0);

    xfer(1, 0, 2'b10, 32'h0000_0104, 32'h76543210, 0);
    xfer(0, 1, 2'b10, 32'h0000_0004, 32'h0, 0);

    xfer(1, 0, 2'b10, 32'h08, 32'hA5A55A5A, 1);
    xfer(0, 1, 2'b10, 32'h08, 32'h0, 0);
    reset_mid(32'h08, 32'h0BAD0BAD, 1);
    xfer(0, 1, 2'b10, 32'h08, 32'h0, 0);
    reset_mid(32'h08, 32'h0BAD0BAD, 2);
    xfer(0, 1, 2'b10, 32'h08, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 4);
      a = $urandom;
      d = $urandom;
      xfer(op != 0, op == 0 || op == 4, 2'($urandom_range(0, 3)), a, d,
           $urandom_range(0, 7) == 0);
    end

    repeat (5) @(posedge clk);
    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data port: accepts the core's read and write requests, stalls the core through the valid handshake for a programmable number of wait states, and serves the access from an internal word-organised RAM with byte/halfword lane control. It replaces the always-valid stub memory used in core-level benches. It also serves as the data memory in small SoC builds with no cache.

## Interface
- `ADDR_WIDTH`, default 10: word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait states inserted before the access; legal range 0..15.
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr_i` in 32: byte address from the core's `data_addr_o`.
- `data_i` in 32: write data from the core's `data_data_o`, right-justified for byte and halfword writes.
- `sel_i` in 2: access size. 2'b00 is byte, 2'b01 is halfword, 2'b1x is word.
- `we_i` in 1: write request.
- `rd_i` in 1: read request.
- `data_o` out 32: full aligned read word, which goes to the core's `data_data_i`.
- `valid_o` out 1: goes to the core's `data_valid_i`. When low, the core must hold its request.
- `fault_o` out 1: one-cycle misalignment flag. It is present only with `DMEM_ALIGN_CHECK_EN` and tied to 0 otherwise.

## Operation
- Word index is `addr_i[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so accesses alias.
- Lanes are little-endian.
  - Byte write: `data_i[7:0]` goes to lane `addr_i[1:0]`.
  - Halfword write: `data_i[15:0]` goes to lanes {addr_i[1],0} and {addr_i[1],1}. `addr_i[0]` is ignored unless the alignment check is enabled.
  - Word write: all four lanes are written.
- Reads always return the whole word. The core performs lane extraction and sign extension.
- FSM states:
  - IDLE: when `rd_i|we_i` is seen, go to DONE if LATENCY==0 (the access is performed at this edge), else go to WAIT with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle. At cnt==0 the access is performed at the edge and the FSM goes to DONE.
  - DONE: one cycle, then go to IDLE unconditionally.
- Request fields are captured into registers at the IDLE edge. Later changes to the inputs are ignored until the FSM returns to IDLE.
- `valid_o` is combinational.
  - IDLE: `valid_o = ~(rd_i|we_i)`.
  - WAIT: `valid_o = 0`.
  - DONE: `valid_o = 1`.
- A request that is withdrawn during WAIT (pipeline flush) is still completed, and a write still commits. DONE still pulses `valid_o`.
- If `we_i` and `rd_i` are both high, the write wins and `data_o` is unchanged.
- `data_o` is registered. It updates only at the edge where a read access is performed and holds until the next read. Writes never change it.

## Timing
- A request first presented in cycle 0 (FSM in IDLE) sees `valid_o` high in cycle LATENCY+1. The core advances at the end of that cycle.
- Back-to-back requests: DONE is followed by IDLE, so the minimum spacing is LATENCY+2 cycles per access.
- A read following a write to the same word returns the new data. The RAM is written at the access edge, before the next IDLE.
- Reset values:
  - State is IDLE, cnt=0, `data_o`=0, `fault_o`=0.
  - `valid_o` follows the IDLE rule.
- RAM contents are not cleared by reset.
- Reset mid-WAIT returns to IDLE with no write committed. Reset in the same cycle as the access edge also suppresses the write.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A misaligned access is a halfword with `addr_i[0]`=1, or a word with `addr_i[1:0]`≠0.
  - The access still goes through the normal handshake, but no RAM write occurs and `data_o` is unchanged.
  - `fault_o` is high exactly in the DONE cycle.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - Low address bits are silently masked as described above.
  - `fault_o` is constant 0.

## Test plan
- LATENCY=2: word write addr 0x10, data 0xDEADBEEF. `valid_o` is low in cycles 0-2 and high in cycle 3. A subsequent word read of 0x10 gives `data_o`=0xDEADBEEF with `valid_o` high 3 cycles after the request.
- Byte write 0xAA to 0x13 over word 0x11223344 -> read returns 0xAA223344. Halfword write 0x5566 to 0x12 -> read returns 0x55663344.
- LATENCY=0: read 0x20 holding 0xCAFEF00D -> `valid_o`=0 in cycle 0, `valid_o`=1 and `data_o`=0xCAFEF00D in cycle 1.
- Write to 0x08 with `rd_i`/`we_i` dropped in cycle 1 -> `valid_o` still pulses in cycle 3, and a later read of 0x08 returns the new data. A second run with `rst` asserted in cycle 1 -> old data retained and FSM in IDLE.
- With `DMEM_ALIGN_CHECK_EN`: word write 0x12345678 to 0x06 -> `fault_o`=1 only in the DONE cycle, and word 0x04 is unchanged. Without the macro: the same write lands in word 0x04 and `fault_o` stays 0.
- Aliasing with ADDR_WIDTH=6: write 0x0000_0104 -> a read of 0x0000_0004 returns the same word.
